// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU pipeline definitions.
//   - Bit positions of the 8-bit decode control bundle.
//   - ALUOp encodings used by the decoder and the ALU control.
//   - REG_ZERO, the hard-wired zero register address.
package cpu_pkg;

  // Control bundle bit map
  localparam int CTRL_ALUSRC   = 0;
  localparam int CTRL_ALUOP_LO = 1;
  localparam int CTRL_ALUOP_HI = 2;
  localparam int CTRL_REGDST   = 3;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_REGWRITE = 6;
  localparam int CTRL_MEMTOREG = 7;

  // ALUOp encodings
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_RTYPE = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Destination register select: rd for R-type (RegDst=1), rt otherwise.
  function automatic logic [4:0] sel_dst(input logic reg_dst,
                                         input logic [4:0] rd,
                                         input logic [4:0] rt);
    return reg_dst ? rd : rt;
  endfunction

endpackage

// File: rtl/pipe_reg_en.sv
// pipe_reg_en: generic pipeline register with load enable and synchronous clear.
//   clk  in  clock
//   en   in  load d into q when high (ignored while clr is high)
//   clr  in  synchronous clear to zero; has priority over en
//   d    in  WIDTH next value
//   q    out WIDTH registered value
// Shared by the IF/ID, ID/EX and EX/MEM stages.
module pipe_reg_en #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register.
//   Captures the decode control bundle, operands, immediate and register
//   addresses, and presents them to EX one cycle later with the control
//   split into EX/M/WB fields. The write destination (rd/rt) is resolved
//   before the register, and RegWrite to $0 is suppressed here.
// Edge priority: rst_i > flush_i > stall_i > load.
// Ports:
//   clk_i, rst_i (sync, active high), stall_i (hold), flush_i (bubble)
//   ctrl_i, pc_i, rs_data_i, rt_data_i, imm_i, rs/rt/rd_addr_i : from ID
//   valid_o, alu_src_o, alu_op_o, mem_read_o, mem_write_o,
//   reg_write_o, mem_to_reg_o, pc_o, rs_data_o, rt_data_o, imm_o,
//   rs_addr_o, rt_addr_o, dst_addr_o : to EX
//   bubble_cnt_o, stall_cnt_o : performance counters
// Configuration macro: ID_EX_PERF_EN adds the saturating bubble/stall
// counters and their ports; without it they are absent.
module id_ex_pipe_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [4:0]        rs_addr_i,
  input  logic [4:0]        rt_addr_i,
  input  logic [4:0]        rd_addr_i,
  output logic              valid_o,
  output logic              alu_src_o,
  output logic [1:0]        alu_op_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              reg_write_o,
  output logic              mem_to_reg_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [4:0]        rs_addr_o,
  output logic [4:0]        rt_addr_o,
  output logic [4:0]        dst_addr_o
`ifdef ID_EX_PERF_EN
  ,
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

  localparam int CG_W = 8;          // valid + 7 control outputs
  localparam int DG_W = 4 * DATA_W; // pc, rs, rt, imm
  localparam int AG_W = 15;         // rs, rt, dst addresses

  // Reset and flush both produce an all-zero stage; stall simply withholds
  // the load enable. Because clr outranks en, flush beats stall.
  logic reg_clr;
  logic reg_en;
  assign reg_clr = rst_i | flush_i;
  assign reg_en  = ~stall_i;

  logic [4:0]      dst_d;
  logic            reg_write_d;
  logic [CG_W-1:0] ctrl_grp_d, ctrl_grp_q;
  logic [DG_W-1:0] data_grp_d, data_grp_q;
  logic [AG_W-1:0] addr_grp_d, addr_grp_q;

  always_comb begin
    dst_d       = sel_dst(ctrl_i[CTRL_REGDST], rd_addr_i, rt_addr_i);
    // A write to $0 would be discarded anyway; killing it here keeps the
    // forwarding unit from matching on $0.
    reg_write_d = ctrl_i[CTRL_REGWRITE] & (dst_d != REG_ZERO);
    ctrl_grp_d  = {1'b1,
                   ctrl_i[CTRL_MEMTOREG],
                   reg_write_d,
                   ctrl_i[CTRL_MEMWRITE],
                   ctrl_i[CTRL_MEMREAD],
                   ctrl_i[CTRL_ALUOP_HI:CTRL_ALUOP_LO],
                   ctrl_i[CTRL_ALUSRC]};
    data_grp_d  = {pc_i, rs_data_i, rt_data_i, imm_i};
    addr_grp_d  = {rs_addr_i, rt_addr_i, dst_d};
  end

  pipe_reg_en #(.WIDTH(CG_W)) u_ctrl_reg (
    .clk(clk_i), .en(reg_en), .clr(reg_clr), .d(ctrl_grp_d), .q(ctrl_grp_q)
  );

  pipe_reg_en #(.WIDTH(DG_W)) u_data_reg (
    .clk(clk_i), .en(reg_en), .clr(reg_clr), .d(data_grp_d), .q(data_grp_q)
  );

  pipe_reg_en #(.WIDTH(AG_W)) u_addr_reg (
    .clk(clk_i), .en(reg_en), .clr(reg_clr), .d(addr_grp_d), .q(addr_grp_q)
  );

  assign {valid_o, mem_to_reg_o, reg_write_o, mem_write_o,
          mem_read_o, alu_op_o, alu_src_o}           = ctrl_grp_q;
  assign {pc_o, rs_data_o, rt_data_o, imm_o}         = data_grp_q;
  assign {rs_addr_o, rt_addr_o, dst_addr_o}          = addr_grp_q;

`ifdef ID_EX_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d,  stall_cnt_q;

  // Saturating counters; a cycle with both flush and stall is a bubble only.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (rst_i) begin
      bubble_cnt_d = '0;
      stall_cnt_d  = '0;
    end else if (flush_i) begin
      if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    end else if (stall_i) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    bubble_cnt_q <= bubble_cnt_d;
    stall_cnt_q  <= stall_cnt_d;
  end

  assign bubble_cnt_o = bubble_cnt_q;
  assign stall_cnt_o  = stall_cnt_q;
`endif

endmodule
